ps2_command_out: RTL and testbench
==================================

PS2_COMMAND_OUT -- requirements
Module: ps2_command_out

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000; system clock frequency used to derive all timing counts.
REQ-002 SHALL have parameter INHIBIT_US, default 100; host clock-inhibit duration in microseconds.
REQ-003 SHALL have parameter START_TIMEOUT_US, default 15000; maximum wait for the device's first clock falling edge.
REQ-004 SHALL have parameter XFER_TIMEOUT_US, default 2000; maximum duration from the first falling edge to the ACK.
REQ-005 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port send_command  input  1  one-cycle request to transmit the_command.
REQ-008 SHALL have port the_command  input  8  command byte, captured when the request is accepted.
REQ-009 SHALL have port ps2_clk_in  input  1  raw (asynchronous) PS2_CLK line level.
REQ-010 SHALL have port ps2_dat_in  input  1  raw (asynchronous) PS2_DAT line level.
REQ-011 SHALL have port ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release (top level ties to 1'bz).
REQ-012 SHALL have port ps2_dat_oe  output  1  1 = pull PS2_DAT low; 0 = release.
REQ-013 SHALL have port busy  output  1  high from request acceptance until the done or error pulse.
REQ-014 SHALL have port command_was_sent  output  1  one-cycle pulse on a valid device ACK.
REQ-015 SHALL have port error_communication_timed_out  output  1  one-cycle pulse on any timeout.

Function
REQ-016 SHALL pass ps2_clk_in/ps2_dat_in through a 2-FF synchronizer; a clock falling edge is registered-previous=1 and current=0.
REQ-017 SHALL implement states IDLE, INHIBIT, REQ_START, TX_BITS, WAIT_ACK, WAIT_RELEASE.
REQ-018 IDLE: when send_command=1, SHALL latch the_command, compute odd parity (~^byte), clear the counters, and go to INHIBIT; busy rises on the next cycle.
REQ-019 send_command while busy=1 SHALL be ignored; no queuing.
REQ-020 INHIBIT: ps2_clk_oe=1 for exactly CLK_HZ*INHIBIT_US/1e6 cycles (5000 at defaults); ps2_dat_oe=1 during the final cycle of INHIBIT; then go to REQ_START.
REQ-021 REQ_START: ps2_clk_oe=0, ps2_dat_oe=1 (start bit); on the first falling edge, go to TX_BITS with bit index 0; with no edge within START_TIMEOUT cycles (750000), raise the error pulse.
REQ-022 TX_BITS: on falling edges 1..8, SHALL drive data bit 0..7 (LSB first; ps2_dat_oe = ~bit); on edge 9, drive parity; on edge 10, release data (stop bit); then go to WAIT_ACK.
REQ-023 WAIT_ACK: on the next falling edge (edge 11), sample synchronized data; 0 -> WAIT_RELEASE; 1 -> error pulse.
REQ-024 WAIT_RELEASE: when synchronized clk=1 and dat=1, raise the command_was_sent pulse and go to IDLE.
REQ-025 The XFER_TIMEOUT counter (100000 cycles) SHALL run from entry to TX_BITS through WAIT_RELEASE; on expiry, raise the error pulse.
REQ-026 On any error, SHALL release both lines in the same cycle as the pulse and return to IDLE.
REQ-027 command_was_sent and error_communication_timed_out SHALL never be high in the same cycle; busy SHALL fall in the cycle after the pulse.
REQ-028 The bit index SHALL be 4 bits and saturate; timeout counters SHALL be 20 bits and saturate, never wrap.
REQ-029 Outside INHIBIT, REQ_START and TX_BITS, both oe outputs SHALL be 0.

Reset
REQ-030 On reset=1, SHALL enter IDLE and clear busy, both oe outputs, both pulses, the counters, the synchronizers (to 1) and the latched byte.
REQ-031 Reset asserted mid-transfer SHALL release both lines on the next clock edge and emit no pulse.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum and the cycle-count constants derived from CLK_HZ and the microsecond parameters.
REQ-033 Sub-module ps2_sync_edge SHALL hold the 2-FF synchronizer and the falling-edge detector; two instances, one for clock and one for data.

Verification
REQ-034 Command 0xF4, a device model clocking at 12.5 kHz that ACKs -> observed bits 0,0,0,1,0,1,1,1,1, parity 0, stop 1; one command_was_sent pulse.
REQ-035 Command 0xFF -> parity bit 1 observed; INHIBIT measures exactly 5000 cycles of ps2_clk_oe=1.
REQ-036 No device clock after the request -> error pulse exactly 750000 cycles after REQ_START entry; lines released.
REQ-037 Device leaves data high at edge 11 -> error pulse, no command_was_sent.
REQ-038 Device stops clocking after edge 5 -> error pulse 100000 cycles after the first edge.
REQ-039 reset=1 during TX_BITS, and send_command while busy -> lines released next cycle, no pulses; the second request is ignored.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device command transmitter.
package ps2_pkg;

    localparam int unsigned DEF_CLK_HZ           = 50_000_000;
    localparam int unsigned DEF_INHIBIT_US       = 100;
    localparam int unsigned DEF_START_TIMEOUT_US = 15_000;
    localparam int unsigned DEF_XFER_TIMEOUT_US  = 2_000;

    localparam int unsigned CNT_W     = 20;
    localparam int unsigned BIT_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INHIBIT      = 3'd1,
        ST_REQ_START    = 3'd2,
        ST_TX_BITS      = 3'd3,
        ST_WAIT_ACK     = 3'd4,
        ST_WAIT_RELEASE = 3'd5
    } ps2_state_e;

    // Last counter value of a microsecond interval (duration in cycles minus one),
    // clamped to at least one cycle and to the counter range.
    function automatic logic [CNT_W-1:0] last_count(input longint unsigned clk_hz,
                                                    input longint unsigned us);
        longint unsigned cycles;
        cycles = (clk_hz * us) / 64'd1_000_000;
        if (cycles == 64'd0) begin
            cycles = 64'd1;
        end
        if (cycles > (64'd1 << CNT_W)) begin
            cycles = 64'd1 << CNT_W;
        end
        return CNT_W'(cycles - 64'd1);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge detector.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the raw line and keep the previous synchronized level; idle-high on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level  = r_sync;
    assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK, with start and transfer timeouts.
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ           = DEF_CLK_HZ,
    parameter int unsigned INHIBIT_US       = DEF_INHIBIT_US,
    parameter int unsigned START_TIMEOUT_US = DEF_START_TIMEOUT_US,
    parameter int unsigned XFER_TIMEOUT_US  = DEF_XFER_TIMEOUT_US
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_command,
    input  logic [7:0] the_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = last_count(64'(CLK_HZ), 64'(INHIBIT_US));
    localparam logic [CNT_W-1:0] START_LAST   = last_count(64'(CLK_HZ), 64'(START_TIMEOUT_US));
    localparam logic [CNT_W-1:0] XFER_LAST    = last_count(64'(CLK_HZ), 64'(XFER_TIMEOUT_US));
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [BIT_IDX_W-1:0] IDX_MAX  = '1;

    ps2_state_e           r_state;
    logic [7:0]           r_byte;
    logic                 r_parity;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_xfer_cnt;
    logic                 r_clk_oe;
    logic                 r_dat_oe;
    logic                 r_busy;
    logic                 r_sent;
    logic                 r_err;

    ps2_state_e           w_state_n;
    logic [7:0]           w_byte_n;
    logic                 w_parity_n;
    logic [BIT_IDX_W-1:0] w_bit_idx_n;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [CNT_W-1:0]     w_xfer_cnt_n;
    logic                 w_clk_oe_n;
    logic                 w_dat_oe_n;
    logic                 w_busy_n;
    logic                 w_sent_n;
    logic                 w_err_n;

    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_xfer_inc;
    logic [BIT_IDX_W-1:0] w_bit_inc;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .i_raw    (ps2_clk_in),
        .o_level  (w_clk_level),
        .o_fall_c (w_clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .i_raw    (ps2_dat_in),
        .o_level  (w_dat_level),
        .o_fall_c (w_dat_fall_unused)
    );

    // Saturating increments; counters never wrap back to zero.
    assign w_cnt_inc  = (r_cnt == CNT_MAX)      ? r_cnt      : r_cnt + CNT_W'(1);
    assign w_xfer_inc = (r_xfer_cnt == CNT_MAX) ? r_xfer_cnt : r_xfer_cnt + CNT_W'(1);
    assign w_bit_inc  = (r_bit_idx == IDX_MAX)  ? r_bit_idx  : r_bit_idx + BIT_IDX_W'(1);

    // Next-state and next-output logic; lines default released, pulses default low.
    always_comb begin
        w_state_n    = r_state;
        w_byte_n     = r_byte;
        w_parity_n   = r_parity;
        w_bit_idx_n  = r_bit_idx;
        w_cnt_n      = r_cnt;
        w_xfer_cnt_n = r_xfer_cnt;
        w_clk_oe_n   = 1'b0;
        w_dat_oe_n   = 1'b0;
        w_busy_n     = r_busy;
        w_sent_n     = 1'b0;
        w_err_n      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_n = 1'b0;
                if (send_command && !r_busy) begin
                    w_state_n    = ST_INHIBIT;
                    w_byte_n     = the_command;
                    w_parity_n   = ~^the_command;
                    w_bit_idx_n  = '0;
                    w_cnt_n      = '0;
                    w_xfer_cnt_n = '0;
                    w_busy_n     = 1'b1;
                    w_clk_oe_n   = 1'b1;
                    w_dat_oe_n   = (INHIBIT_LAST == '0);
                end
            end

            ST_INHIBIT: begin
                if (r_cnt >= INHIBIT_LAST) begin
                    w_state_n  = ST_REQ_START;
                    w_cnt_n    = '0;
                    w_dat_oe_n = 1'b1;
                end else begin
                    w_cnt_n    = w_cnt_inc;
                    w_clk_oe_n = 1'b1;
                    w_dat_oe_n = (w_cnt_inc >= INHIBIT_LAST);
                end
            end

            ST_REQ_START: begin
                w_dat_oe_n = 1'b1;
                if (w_clk_fall) begin
                    w_state_n    = ST_TX_BITS;
                    w_bit_idx_n  = '0;
                    w_xfer_cnt_n = '0;
                    w_dat_oe_n   = ~r_byte[0];
                end else if (r_cnt >= START_LAST) begin
                    w_state_n  = ST_IDLE;
                    w_err_n    = 1'b1;
                    w_dat_oe_n = 1'b0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end

            ST_TX_BITS: begin
                w_dat_oe_n = r_dat_oe;
                if (r_xfer_cnt >= XFER_LAST) begin
                    w_state_n  = ST_IDLE;
                    w_err_n    = 1'b1;
                    w_dat_oe_n = 1'b0;
                end else begin
                    w_xfer_cnt_n = w_xfer_inc;
                    if (w_clk_fall) begin
                        w_bit_idx_n = w_bit_inc;
                        if (w_bit_inc <= BIT_IDX_W'(7)) begin
                            w_dat_oe_n = ~r_byte[w_bit_inc[2:0]];
                        end else if (w_bit_inc == BIT_IDX_W'(8)) begin
                            w_dat_oe_n = ~r_parity;
                        end else begin
                            w_dat_oe_n = 1'b0;
                            w_state_n  = ST_WAIT_ACK;
                        end
                    end
                end
            end

            ST_WAIT_ACK: begin
                if (r_xfer_cnt >= XFER_LAST) begin
                    w_state_n = ST_IDLE;
                    w_err_n   = 1'b1;
                end else begin
                    w_xfer_cnt_n = w_xfer_inc;
                    if (w_clk_fall) begin
                        if (!w_dat_level) begin
                            w_state_n = ST_WAIT_RELEASE;
                        end else begin
                            w_state_n = ST_IDLE;
                            w_err_n   = 1'b1;
                        end
                    end
                end
            end

            ST_WAIT_RELEASE: begin
                if (r_xfer_cnt >= XFER_LAST) begin
                    w_state_n = ST_IDLE;
                    w_err_n   = 1'b1;
                end else begin
                    w_xfer_cnt_n = w_xfer_inc;
                    if (w_clk_level && w_dat_level) begin
                        w_state_n = ST_IDLE;
                        w_sent_n  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases both lines and suppresses pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_xfer_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_byte     <= w_byte_n;
            r_parity   <= w_parity_n;
            r_bit_idx  <= w_bit_idx_n;
            r_cnt      <= w_cnt_n;
            r_xfer_cnt <= w_xfer_cnt_n;
            r_clk_oe   <= w_clk_oe_n;
            r_dat_oe   <= w_dat_oe_n;
            r_busy     <= w_busy_n;
            r_sent     <= w_sent_n;
            r_err      <= w_err_n;
        end
    end

    assign ps2_clk_oe                    = r_clk_oe;
    assign ps2_dat_oe                    = r_dat_oe;
    assign busy                          = r_busy;
    assign command_was_sent              = r_sent;
    assign error_communication_timed_out = r_err;

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out with an open-drain PS/2 device model.
module tb_ps2_command_out;

    localparam int unsigned CLK_HZ_T   = 2_000_000;
    localparam int unsigned INHIBIT_US = 10;
    localparam int unsigned START_US   = 300;
    localparam int unsigned XFER_US    = 200;
    localparam int INH_CYC   = int'((CLK_HZ_T / 1_000_000) * INHIBIT_US);
    localparam int START_CYC = int'((CLK_HZ_T / 1_000_000) * START_US);
    localparam int XFER_CYC  = int'((CLK_HZ_T / 1_000_000) * XFER_US);
    localparam int H         = 10;
    localparam int SYNC_LAT  = 3;

    logic       clk;
    logic       reset;
    logic       send_command;
    logic [7:0] the_command;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       clk_line;
    logic       dat_line;

    int   cyc          = 0;
    int   sent_cnt     = 0;
    int   err_cnt      = 0;
    int   both_cnt     = 0;
    int   lines_bad    = 0;
    int   busy_bad     = 0;
    int   last_err_cyc = -1;
    logic prev_pulse   = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   first_fall_cyc = -1;
    logic exp_q[$];

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_command_out #(
        .CLK_HZ           (CLK_HZ_T),
        .INHIBIT_US       (INHIBIT_US),
        .START_TIMEOUT_US (START_US),
        .XFER_TIMEOUT_US  (XFER_US)
    ) dut (
        .CLOCK_50                      (clk),
        .reset                         (reset),
        .send_command                  (send_command),
        .the_command                   (the_command),
        .ps2_clk_in                    (clk_line),
        .ps2_dat_in                    (dat_line),
        .ps2_clk_oe                    (ps2_clk_oe),
        .ps2_dat_oe                    (ps2_dat_oe),
        .busy                          (busy),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and records pulse-cycle invariants.
    always @(negedge clk) begin
        if (command_was_sent) sent_cnt <= sent_cnt + 1;
        if (error_communication_timed_out) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (command_was_sent && error_communication_timed_out) both_cnt <= both_cnt + 1;
        if ((command_was_sent || error_communication_timed_out) && (ps2_clk_oe || ps2_dat_oe))
            lines_bad <= lines_bad + 1;
        if (((command_was_sent || error_communication_timed_out) && !busy) || (prev_pulse && busy))
            busy_bad <= busy_bad + 1;
        prev_pulse <= command_was_sent | error_communication_timed_out;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] c);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(c[i]);
        exp_q.push_back(~^c);
        exp_q.push_back(1'b1);
    endtask

    task automatic pop_check(input string tag);
        logic expb;
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check(tag, 32'(dat_line), 32'(expb));
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(posedge clk); #1;
        send_command = 1'b1;
        the_command  = c;
        @(posedge clk); #1;
        send_command = 1'b0;
        the_command  = 8'h00;
    endtask

    // Counts INHIBIT cycles and returns at the negedge of the first REQ_START cycle.
    task automatic measure_inhibit(output int inh, output int both, output int entry);
        bit seen;
        seen  = 1'b0;
        inh   = 0;
        both  = 0;
        entry = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                seen = 1'b1;
                inh++;
                if (ps2_dat_oe) both++;
            end else if (seen) begin
                entry = cyc;
                break;
            end
        end
    endtask

    // Device: samples the line on each rising clock, ACKs after the stop bit if asked.
    task automatic dev_frame(input int n_falls, input bit ack);
        wait_cyc(H);
        pop_check("start_bit");
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1) first_fall_cyc = cyc;
            wait_cyc(H);
            dev_clk_low = 1'b0;
            if (k == 11) dev_dat_low = 1'b0;
            if (k <= 10) pop_check($sformatf("frame_bit_%0d", k));
            if (k == 10 && ack) dev_dat_low = 1'b1;
            wait_cyc(H);
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sent_cnt + err_cnt >= target) break;
            @(posedge clk); #1;
        end
        check(tag, 32'(sent_cnt + err_cnt), 32'(target));
    endtask

    task automatic run_good(input logic [7:0] c, input string tag);
        int s0, e0, inh, both, entry;
        s0 = sent_cnt;
        e0 = err_cnt;
        push_frame(c);
        check({tag, "_busy_before"}, 32'(busy), 32'd0);
        send_cmd(c);
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        measure_inhibit(inh, both, entry);
        check({tag, "_inhibit_cycles"}, 32'(inh), 32'(INH_CYC));
        check({tag, "_inhibit_dat_overlap"}, 32'(both), 32'd1);
        check({tag, "_req_start_dat_oe"}, 32'(ps2_dat_oe), 32'd1);
        dev_frame(11, 1'b1);
        wait_pulses(s0 + e0 + 1, 200, {tag, "_pulse_count"});
        check({tag, "_sent"}, 32'(sent_cnt - s0), 32'd1);
        check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
        wait_cyc(2);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int s0, e0, inh, both, entry;

        reset        = 1'b1;
        send_command = 1'b0;
        the_command  = 8'h00;
        dev_clk_low  = 1'b0;
        dev_dat_low  = 1'b0;

        // Reset state.
        wait_cyc(5);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_sent", 32'(command_was_sent), 32'd0);
        check("rst_err", 32'(error_communication_timed_out), 32'd0);
        reset = 1'b0;
        wait_cyc(5);

        // Full transfers with ACK.
        run_good(8'hF4, "f4");
        wait_cyc(20);
        run_good(8'hFF, "ff");
        wait_cyc(20);

        // No device clock: start timeout.
        s0 = sent_cnt; e0 = err_cnt;
        send_cmd(8'h55);
        measure_inhibit(inh, both, entry);
        check("nostart_inhibit_cycles", 32'(inh), 32'(INH_CYC));
        wait_pulses(s0 + e0 + 1, START_CYC + 100, "nostart_pulse_count");
        check("nostart_err", 32'(err_cnt - e0), 32'd1);
        check("nostart_sent", 32'(sent_cnt - s0), 32'd0);
        check("nostart_err_time", 32'(last_err_cyc), 32'(entry + START_CYC));
        check("nostart_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("nostart_dat_oe", 32'(ps2_dat_oe), 32'd0);
        wait_cyc(20);

        // Device leaves data high on the ACK edge.
        s0 = sent_cnt; e0 = err_cnt;
        push_frame(8'h3A);
        send_cmd(8'h3A);
        measure_inhibit(inh, both, entry);
        dev_frame(11, 1'b0);
        wait_pulses(s0 + e0 + 1, 200, "noack_pulse_count");
        check("noack_err", 32'(err_cnt - e0), 32'd1);
        check("noack_sent", 32'(sent_cnt - s0), 32'd0);
        wait_cyc(20);

        // Device stops after five clocks: transfer timeout.
        s0 = sent_cnt; e0 = err_cnt;
        push_frame(8'hC3);
        send_cmd(8'hC3);
        measure_inhibit(inh, both, entry);
        dev_frame(5, 1'b0);
        exp_q.delete();
        wait_pulses(s0 + e0 + 1, XFER_CYC + 200, "stall_pulse_count");
        check("stall_err", 32'(err_cnt - e0), 32'd1);
        check("stall_sent", 32'(sent_cnt - s0), 32'd0);
        check("stall_err_time", 32'(last_err_cyc), 32'(first_fall_cyc + SYNC_LAT + XFER_CYC));
        wait_cyc(20);

        // Request while busy is ignored: only the first byte goes out.
        s0 = sent_cnt; e0 = err_cnt;
        push_frame(8'hA5);
        send_cmd(8'hA5);
        measure_inhibit(inh, both, entry);
        send_cmd(8'h3C);
        dev_frame(11, 1'b1);
        wait_pulses(s0 + e0 + 1, 200, "busyreq_pulse_count");
        check("busyreq_sent", 32'(sent_cnt - s0), 32'd1);
        wait_cyc(60);
        check("busyreq_no_second_xfer_busy", 32'(busy), 32'd0);
        check("busyreq_no_second_xfer_clk", 32'(ps2_clk_oe), 32'd0);
        check("busyreq_total_pulses", 32'(sent_cnt + err_cnt), 32'(s0 + e0 + 1));

        // Reset in the middle of TX_BITS.
        s0 = sent_cnt; e0 = err_cnt;
        push_frame(8'h12);
        send_cmd(8'h12);
        measure_inhibit(inh, both, entry);
        dev_frame(3, 1'b0);
        exp_q.delete();
        check("midrst_dat_driven", 32'(ps2_dat_oe), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(XFER_CYC + 50);
        check("midrst_no_pulses", 32'(sent_cnt + err_cnt), 32'(s0 + e0));

        // Pulse-cycle invariants gathered across the run.
        check("never_both_pulses", 32'(both_cnt), 32'd0);
        check("lines_released_at_pulse", 32'(lines_bad), 32'd0);
        check("busy_pulse_alignment", 32'(busy_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
